// File: rtl/sseg_scan_driver_pkg.sv
// Shared definitions for the seven-segment display path: segment patterns,
// "all off" constants, the latched display-set record and an anode helper.
package sseg_pkg;

  // All four common-anode digits disabled (anodes are active-low).
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  // Every segment including the decimal point dark (segments are active-low).
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by the hex nibble.
  // Listed from entry 15 (F) down to entry 0 (0).
  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Digit position 0..3, digit 0 is the rightmost.
  typedef logic [1:0] digit_idx_t;

  // Everything a single load captures: the hex value, the decimal points
  // and the per-digit blank mask. Held once as "pending" and once as "shown".
  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_set_t;

  // Active-low anode vector that enables exactly the given digit.
  function automatic logic [3:0] digit_anode(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Connection between the processor core and the scan driver. The master
// side presents value/dp/blank with a load strobe; the slave side drives the
// multiplexed display pins and the frame-complete pulse back.
interface sseg_scan_driver_if;

  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        load;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_done;

  modport master (
    output value, dp, blank, load,
    input  an, sseg, frame_done
  );

  modport slave (
    input  value, dp, blank, load,
    output an, sseg, frame_done
  );

endinterface

// File: rtl/sseg_scan_driver_hex_to_sseg.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational so any display path can reuse it.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_PATTERNS[nibble_i];

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver. A prescaler slices time into
// digit slots; the first GUARD cycles of every slot keep all anodes off so
// the previous digit's segments never ghost onto the next one. New values
// are parked in a pending set and only move to the shown set at the end of
// a full frame, so a frame never mixes old and new digits.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,  // clock cycles per digit slot, >= 2
  parameter int GUARD       = 16      // blanked cycles at slot start, < REFRESH_DIV
)(
  input  logic                clk,
  input  logic                reset,
  sseg_scan_driver_if.slave   bus
);

  localparam int                CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_GUARD = CNT_W'(GUARD);
  localparam bit                HAS_GUARD = (GUARD > 0);
  localparam digit_idx_t        IDX_LAST  = 2'd3;

  // Scan position.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  digit_idx_t       idx_q, idx_d;

  // Pending (waiting for a frame boundary) and displayed content.
  disp_set_t        pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  disp_set_t        disp_q, disp_d;

  // Registered display outputs.
  logic [3:0]       an_q, an_d;
  logic [7:0]       sseg_q, sseg_d;
  logic             frame_done_q, frame_done_d;

  // Decode helpers.
  logic             tick;
  logic             boundary;
  logic             in_guard;
  disp_set_t        load_set;
  logic [3:0]       nibble;
  logic [6:0]       seg7;

  hex_to_sseg u_hex (
    .nibble_i (nibble),
    .seg_o    (seg7)
  );

  // Next scan position, load/frame-transfer bookkeeping and the output image.
  always_comb begin
    // NOTE: every signal written here is given a value up front, so no path
    // leaves one unassigned and no latch can be inferred.
    tick         = (cnt_q == CNT_LAST);
    boundary     = tick && (idx_q == IDX_LAST);
    in_guard     = HAS_GUARD && (cnt_q < CNT_GUARD);
    load_set     = '{value: bus.value, dp: bus.dp, blank: bus.blank};
    nibble       = disp_q.value[{idx_q, 2'b00} +: 4];

    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? idx_q + 1'b1 : idx_q;

    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    disp_d       = disp_q;

    if (boundary) begin
      // A load landing exactly on the boundary skips the pending stage.
      if (bus.load) begin
        disp_d = load_set;
      end else if (pend_valid_q) begin
        disp_d = pend_q;
      end
      pend_valid_d = 1'b0;
    end else if (bus.load) begin
      // Last load before the boundary wins.
      pend_d       = load_set;
      pend_valid_d = 1'b1;
    end

    // Outputs lag the scan position by one cycle; segments are driven even
    // while anodes are off, so only reset ever shows SEG_OFF.
    an_d         = (in_guard || disp_q.blank[idx_q]) ? ANODES_OFF : digit_anode(idx_q);
    sseg_d       = {~disp_q.dp[idx_q], seg7};
    frame_done_d = boundary;
  end

  // State update; reset aborts any frame in progress and drops pending loads.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values regardless of statement order.
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      // NOTE: the pending and display sets are explicitly cleared because the
      // display must come back up showing zeros, not whatever was held.
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      disp_q       <= '0;
      an_q         <= ANODES_OFF;
      sseg_q       <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      disp_q       <= disp_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver with REFRESH_DIV=4, GUARD=1.
// A positional reference model pushes the expected outputs of every cycle to
// a scoreboard queue; a vector table adds hand-derived spot checks.
module tb_sseg_scan_driver;

  localparam int RD = 4;
  localparam int GD = 1;

  logic clk = 1'b0;
  logic reset;

  sseg_scan_driver_if bus();

  sseg_scan_driver #(
    .REFRESH_DIV (RD),
    .GUARD       (GD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
    logic       fd;
  } obs_t;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
  } set_t;

  typedef struct {
    int         skip;   // idle cycles before this vector
    bit         rst;
    bit         load;
    set_t       in;
    obs_t       exp;
    string      name;
  } vec_t;

  logic [6:0] hex_tab [16];
  obs_t       sb_q [$];
  vec_t       vecs [$];
  int         n_pass  = 0;
  int         n_total = 0;

  // Reference model state: edges since reset release, shown and next set.
  int   m_edge;
  set_t m_cur;
  set_t m_nxt;
  bit   m_nv;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected outputs after the coming edge, derived from the edge's position
  // within the frame; then account for the load applied on this edge.
  task automatic model_step(input bit rst, input bit load, input set_t in, output obs_t e);
    int cnt;
    int idx;
    if (rst) begin
      e      = '{4'hF, 8'hFF, 1'b0};
      m_edge = 0;
      m_cur  = '0;
      m_nxt  = '0;
      m_nv   = 1'b0;
    end else begin
      m_edge++;
      cnt    = (m_edge - 1) % RD;
      idx    = ((m_edge - 1) / RD) % 4;
      e.an   = (cnt < GD || m_cur.bl[idx]) ? 4'hF : ~(4'b0001 << idx);
      e.sseg = {~m_cur.dp[idx], hex_tab[m_cur.v[idx*4 +: 4]]};
      e.fd   = (cnt == RD - 1) && (idx == 3);
      if (load) begin
        m_nxt = in;
        m_nv  = 1'b1;
      end
      if (e.fd && m_nv) begin
        m_cur = m_nxt;
        m_nv  = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, queue the expectation, sample #1 after the edge.
  task automatic cycle(input bit rst, input bit load, input set_t in, output obs_t act);
    obs_t e;
    reset     = rst;
    bus.load  = load;
    bus.value = in.v;
    bus.dp    = in.dp;
    bus.blank = in.bl;
    model_step(rst, load, in, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    act = '{bus.an, bus.sseg, bus.frame_done};
    e   = sb_q.pop_front();
    check($sformatf("sb_an@%0d", m_edge),   {4'h0, act.an}, {4'h0, e.an});
    check($sformatf("sb_sseg@%0d", m_edge), act.sseg,       e.sseg);
    check($sformatf("sb_fd@%0d", m_edge),   {7'h0, act.fd}, {7'h0, e.fd});
  endtask

  function automatic vec_t mk(input int skip, input bit rst, input bit load,
                              input logic [15:0] v, input logic [3:0] dp,
                              input logic [3:0] bl, input logic [3:0] an,
                              input logic [7:0] ss, input bit fd, input string name);
    vec_t r;
    r.skip = skip;
    r.rst  = rst;
    r.load = load;
    r.in   = '{v, dp, bl};
    r.exp  = '{an, ss, fd};
    r.name = name;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t act;
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset     = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    bus.dp    = '0;
    bus.blank = '0;

    //              skip rst ld value     dp      blank   an      sseg   fd name
    vecs.push_back(mk(0, 1, 0, 16'h0000, 4'h0, 4'h0, 4'b1111, 8'hFF, 0, "rst_0"));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 4'h0, 4'h0, 4'b1111, 8'hFF, 0, "rst_1"));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 4'h0, 4'h0, 4'b1111, 8'hFF, 0, "rst_2"));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1111, 8'hC0, 0, "guard0"));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1110, 8'hC0, 0, "dig0_zero"));
    vecs.push_back(mk(3, 0, 1, 16'h12AF, 4'b0100, 4'h0, 4'b1101, 8'hC0, 0, "load_mid"));
    vecs.push_back(mk(8, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b0111, 8'hC0, 0, "old_frame"));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b0111, 8'hC0, 1, "frame_done1"));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1111, 8'h8E, 0, "guard_new"));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1110, 8'h8E, 0, "new_dig0"));
    vecs.push_back(mk(3, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1101, 8'h88, 0, "new_dig1"));
    vecs.push_back(mk(3, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1011, 8'h24, 0, "new_dig2_dp"));
    vecs.push_back(mk(3, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b0111, 8'hF9, 0, "new_dig3"));
    vecs.push_back(mk(1, 0, 1, 16'h0008, 4'h0, 4'h0, 4'b0111, 8'hF9, 1, "coincident"));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1110, 8'h80, 0, "bypass_dig0"));
    vecs.push_back(mk(1, 0, 1, 16'h1111, 4'h0, 4'h0, 4'b1110, 8'h80, 0, "load_a"));
    vecs.push_back(mk(3, 0, 1, 16'h2222, 4'h0, 4'b1000, 4'b1101, 8'hC0, 0, "load_b"));
    vecs.push_back(mk(7, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b0111, 8'hC0, 1, "frame_done3"));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1110, 8'hA4, 0, "over_dig0"));
    vecs.push_back(mk(11, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1111, 8'hA4, 0, "blank_dig3"));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1111, 8'hA4, 1, "blank_fd"));
    vecs.push_back(mk(1, 0, 1, 16'hABCD, 4'hF, 4'h0, 4'b1110, 8'hA4, 0, "pend_abcd"));
    vecs.push_back(mk(7, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1011, 8'hA4, 0, "dig2_active"));
    vecs.push_back(mk(0, 1, 0, 16'h0000, 4'h0, 4'h0, 4'b1111, 8'hFF, 0, "rst_mid"));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1111, 8'hC0, 0, "restart_guard"));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1110, 8'hC0, 0, "restart_dig0"));
    vecs.push_back(mk(13, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b0111, 8'hC0, 1, "restart_fd"));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'h0, 4'h0, 4'b1110, 8'hC0, 0, "no_stale"));

    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].skip; k++) cycle(1'b0, 1'b0, '0, act);
      cycle(vecs[i].rst, vecs[i].load, vecs[i].in, act);
      check({vecs[i].name, "_an"},   {4'h0, act.an}, {4'h0, vecs[i].exp.an});
      check({vecs[i].name, "_sseg"}, act.sseg,       vecs[i].exp.sseg);
      check({vecs[i].name, "_fd"},   {7'h0, act.fd}, {7'h0, vecs[i].exp.fd});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
